// File: rtl/vga_640x480.sv
// vga_640x480 -- 640x480@60 VGA timing generator driven by a pixel-rate enable.
// Horizontal and vertical counters advance on enabled edges; sync, position,
// active and end-of-line/frame flags are decoded combinationally from them.
// Optional: define VGA_640X480_FRAME_CNT_EN to add a 16-bit frame counter (o_frame).
module vga_640x480 #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clkenable,
    output logic        o_hs,
    output logic        o_vs,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_active,
    output logic        o_endline,
    output logic        o_endframe
`ifdef VGA_640X480_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized decode points so every compare is 10 bits wide.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_CLAMP    = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_CLAMP    = 9'(V_ACTIVE - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Raster counters: h wraps at end of line and carries into v, which wraps at end of frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_clkenable) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Zero-latency decode; outputs only move when the counters do.
    assign o_hs       = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    assign o_vs       = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    assign o_x        = (r_h_cnt < H_VIS) ? r_h_cnt : X_CLAMP;
    assign o_y        = (r_v_cnt < V_VIS) ? r_v_cnt[8:0] : Y_CLAMP;
    assign o_active   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_endline  = w_h_last;
    assign o_endframe = w_h_last && w_v_last;

`ifdef VGA_640X480_FRAME_CNT_EN
    logic [15:0] r_frame;

    // Count completed frames; the enabled edge leaving the last pixel closes a frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_frame <= '0;
        else if (i_clkenable && w_h_last && w_v_last)
            r_frame <= r_frame + 16'd1;
    end

    assign o_frame = r_frame;
`endif

endmodule

// File: tb/tb_vga_640x480.sv
// tb_vga_640x480 -- directed checks on a default-timing instance (A) and a
// shrunken-timing instance (B) so full frames fit in a short run.
// B timing: H 16/4/6/4 (total 30, hsync 20..25), V 12/2/2/3 (total 19, vsync 14..15).
module tb_vga_640x480;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;

    logic       hs_a, vs_a, act_a, el_a, ef_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic       hs_b, vs_b, act_b, el_b, ef_b;
    logic [9:0] x_b;
    logic [8:0] y_b;
`ifdef VGA_640X480_FRAME_CNT_EN
    logic [15:0] frm_a, frm_b;
`endif

    vga_640x480 u_a (
        .i_clk(clk), .i_rst(rst_a), .i_clkenable(en_a),
        .o_hs(hs_a), .o_vs(vs_a), .o_x(x_a), .o_y(y_a),
        .o_active(act_a), .o_endline(el_a), .o_endframe(ef_a)
`ifdef VGA_640X480_FRAME_CNT_EN
        , .o_frame(frm_a)
`endif
    );

    vga_640x480 #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_clkenable(en_b),
        .o_hs(hs_b), .o_vs(vs_b), .o_x(x_b), .o_y(y_b),
        .o_active(act_b), .o_endline(el_b), .o_endframe(ef_b)
`ifdef VGA_640X480_FRAME_CNT_EN
        , .o_frame(frm_b)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 ns past the last edge for sampling.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_b();
        en_b  = 1'b0;
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        en_b  = 1'b1;
    endtask

    initial begin
        int cnt, chg;
        int el1, el2, ef1, ef2, efhi;
        logic pel, pef;
        logic [9:0] sx;
        logic [8:0] sy;

        // ---------------- instance A: default 640x480 timing ----------------
        step(1);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_active", act_a, 1);
        chk("rst_endline", el_a, 0);
        chk("rst_endframe", ef_a, 0);
`ifdef VGA_640X480_FRAME_CNT_EN
        chk("rst_frame", frm_a, 0);
`endif

        rst_a = 1'b0;
        en_a  = 1'b1;
        step(655);                      // h=655
        chk("h655_hs", hs_a, 1);
        chk("h655_x", x_a, 639);
        chk("h655_active", act_a, 0);
        step(1);                        // h=656
        chk("h656_hs", hs_a, 0);
        step(95);                       // h=751
        chk("h751_hs", hs_a, 0);
        step(1);                        // h=752
        chk("h752_hs", hs_a, 1);
        step(47);                       // h=799
        chk("h799_endline", el_a, 1);
        chk("h799_endframe", ef_a, 0);
        step(1);                        // (0,1)
        chk("wrap_x", x_a, 0);
        chk("wrap_y", y_a, 1);
        chk("wrap_endline", el_a, 0);

        step(320);                      // (320,1)
        en_a = 1'b0;
        chg = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (x_a != 10'd320 || y_a != 9'd1 || hs_a != 1'b1 || act_a != 1'b1)
                chg++;
        end
        chk("a_freeze_changes", chg, 0);
        chk("a_freeze_x", x_a, 320);
        en_a = 1'b1;
        step(1);
        chk("a_resume_x", x_a, 321);

        step(379);                      // (700,1)
        chk("a_h700_x", x_a, 639);
        #2 rst_a = 1'b1;                // between edges
        #1;
        chk("a_arst_x", x_a, 0);
        chk("a_arst_y", y_a, 0);
        chk("a_arst_hs", hs_a, 1);
        #2 rst_a = 1'b0;
        step(1);
        chk("a_after_rst_x", x_a, 1);
        en_a = 1'b0;

        // ---------------- instance B: vertical behaviour ----------------
        reset_b();
        step(14 * 30);                  // (0,14) vsync start
        chk("b_vs_start", vs_b, 0);
        chk("b_vs_y", y_b, 11);
        chk("b_vs_active", act_b, 0);
        cnt = 0;
        for (int i = 0; i < 200 && vs_b == 1'b0; i++) begin
            cnt++;
            step(1);
        end
        chk("b_vs_len", cnt, 60);
        chk("b_vs_after", vs_b, 1);

        // enable toggling every clock: line = 60 clocks, frame = 1140 clocks
        reset_b();
        en_b = 1'b0;
        el1 = -1; el2 = -1; ef1 = -1; ef2 = -1; efhi = 0;
        pel = 1'b0; pef = 1'b0;
        for (int k = 0; k < 2400; k++) begin
            step(1);
            if (el_b && !pel) begin
                if (el1 < 0) el1 = k; else if (el2 < 0) el2 = k;
            end
            if (ef_b && !pef) begin
                if (ef1 < 0) ef1 = k; else if (ef2 < 0) ef2 = k;
            end
            if (ef1 >= 0 && ef2 < 0 && ef_b) efhi++;
            pel = el_b;
            pef = ef_b;
            en_b = ~en_b;
        end
        chk("b_line_clocks", el2 - el1, 60);
        chk("b_frame_clocks", ef2 - ef1, 1140);
        chk("b_endframe_width", efhi, 2);

        // freeze at (8,5)
        reset_b();
        step(5 * 30 + 8);
        chk("b_pos_x", x_b, 8);
        chk("b_pos_y", y_b, 5);
        en_b = 1'b0;
        sx = x_b;
        sy = y_b;
        chg = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (x_b != 10'd8 || y_b != 9'd5 || hs_b != 1'b1 || vs_b != 1'b1 ||
                act_b != 1'b1 || el_b != 1'b0 || ef_b != 1'b0)
                chg++;
        end
        chk("b_freeze_changes", chg, 0);
        chk("b_freeze_x", x_b, 8);
        chk("b_freeze_y", y_b, 5);

        // async reset in blanking (h=22 inside hsync, v=17)
        reset_b();
        step(17 * 30 + 22);
        chk("b_blank_hs", hs_b, 0);
        chk("b_blank_x", x_b, 15);
        chk("b_blank_y", y_b, 11);
        #2 rst_b = 1'b1;
        #1;
        chk("b_arst_x", x_b, 0);
        chk("b_arst_y", y_b, 0);
        chk("b_arst_hs", hs_b, 1);
        chk("b_arst_vs", vs_b, 1);
        #2 rst_b = 1'b0;
        step(1);
        chk("b_after_rst_x", x_b, 1);
        chk("b_after_rst_y", y_b, 0);

`ifdef VGA_640X480_FRAME_CNT_EN
        reset_b();
        chk("b_frame_rst", frm_b, 0);
        step(3 * 570);
        chk("b_frame_3", frm_b, 3);
`endif
        en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
